// File: rtl/accumulator_ingress_arb_pkg.sv
// Shared defaults, channel index type and round-robin grant helper for the
// accumulator ingress arbiter.
package acc_pkg;

    localparam int unsigned ACC_DATA_WIDTH  = 32;
    localparam int unsigned ACC_NUM_CHANNEL = 2;
    localparam int unsigned ACC_SEL_W       = $clog2(ACC_NUM_CHANNEL);
    localparam int unsigned ACC_MAX_CHANNEL = 32;
    localparam int unsigned ACC_MAX_W       = $clog2(ACC_MAX_CHANNEL);

    typedef logic [ACC_SEL_W-1:0] ch_idx_t;

    // First requesting channel after 'last', wrapping modulo num; holds 'last' when idle.
    function automatic int unsigned rr_next(input int unsigned                last,
                                            input logic [ACC_MAX_CHANNEL-1:0] req_mask,
                                            input int unsigned                num);
        int unsigned idx;
        int unsigned grant;
        grant = last;
        for (int unsigned k = ACC_MAX_CHANNEL; k > 0; k--) begin
            if (k <= num) begin
                idx = (last + k) % num;
                if (req_mask[ACC_MAX_W'(idx)]) grant = idx;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/accumulator_ingress_arb_if.sv
// Producer-side and accumulator-side handshake bundle of the ingress arbiter.
interface accumulator_ingress_arb_if
    import acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ACC_DATA_WIDTH,
    parameter int unsigned NUM_CHANNEL = ACC_NUM_CHANNEL
);
    localparam int unsigned SEL_W = $clog2(NUM_CHANNEL);

    logic [NUM_CHANNEL-1:0]            in_val;
    logic [NUM_CHANNEL-1:0]            in_rdy;
    logic [NUM_CHANNEL*DATA_WIDTH-1:0] in_data;
    logic                              o_val;
    logic                              i_rdy;
    logic [DATA_WIDTH-1:0]             o_data;
    logic [SEL_W-1:0]                  o_sel;
    logic [NUM_CHANNEL-1:0]            o_empty;

    modport master (
        output in_val, in_data, i_rdy,
        input  in_rdy, o_val, o_data, o_sel, o_empty
    );

    modport slave (
        input  in_val, in_data, i_rdy,
        output in_rdy, o_val, o_data, o_sel, o_empty
    );

endinterface

// File: rtl/accumulator_ingress_arb_fifo.sv
// Per-channel show-ahead FIFO; full blocks pushes even when a pop happens in
// the same cycle.
module acc_chan_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/accumulator_ingress_arb.sv
// Round-robin ingress arbiter: per-channel FIFOs merged into one registered
// data/select/valid stream feeding accumulator_multi.
module accumulator_ingress_arb
    import acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ACC_DATA_WIDTH,
    parameter int unsigned NUM_CHANNEL = ACC_NUM_CHANNEL,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    accumulator_ingress_arb_if.slave   bus
);
    localparam int unsigned SEL_W = $clog2(NUM_CHANNEL);

    logic [NUM_CHANNEL-1:0]     full;
    logic [NUM_CHANNEL-1:0]     empty;
    logic [NUM_CHANNEL-1:0]     push;
    logic [NUM_CHANNEL-1:0]     pop;
    logic [DATA_WIDTH-1:0]      head [NUM_CHANNEL];
    logic [ACC_MAX_CHANNEL-1:0] req_c;
    logic [SEL_W-1:0]           grant_c;
    logic                       load_en_c;
    logic [SEL_W-1:0]           last_grant;
    logic                       val_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [SEL_W-1:0]           sel_q;

    assign push = bus.in_val & ~full;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_chan
        acc_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (i_flush),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (head[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    // Eligibility uses registered FIFO counts, so same-cycle pushes wait a cycle.
    always_comb begin
        req_c     = ACC_MAX_CHANNEL'(~empty);
        grant_c   = SEL_W'(rr_next(32'(last_grant), req_c, NUM_CHANNEL));
        load_en_c = (!val_q || bus.i_rdy) && (|(~empty));
        pop       = '0;
        if (load_en_c) pop[grant_c] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q      <= 1'b0;
            data_q     <= '0;
            sel_q      <= '0;
            last_grant <= SEL_W'(NUM_CHANNEL - 1);
        end else if (i_flush) begin
            val_q      <= 1'b0;
            data_q     <= '0;
            sel_q      <= '0;
            last_grant <= SEL_W'(NUM_CHANNEL - 1);
        end else if (load_en_c) begin
            val_q      <= 1'b1;
            data_q     <= head[grant_c];
            sel_q      <= grant_c;
            last_grant <= grant_c;
        end else if (bus.i_rdy) begin
            val_q      <= 1'b0;
        end
    end

    assign bus.in_rdy  = ~full;
    assign bus.o_empty = empty;
    assign bus.o_val   = val_q;
    assign bus.o_data  = data_q;
    assign bus.o_sel   = sel_q;

endmodule
